// File: rtl/count_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count_mon_pkg
// Description : Shared defaults, event-record bit positions and the packed
//               event record type for the counter event monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package count_mon_pkg;

  // Default width of the sampled counter value.
  localparam int CNT_W_DEFAULT   = 4;
  // Default width of the saturating wrap tally.
  localparam int TALLY_W_DEFAULT = 8;

  // Bit positions of the event flags inside a record {wrap, match, value}.
  localparam int EVT_WRAP_BIT  = CNT_W_DEFAULT + 1;
  localparam int EVT_MATCH_BIT = CNT_W_DEFAULT;

  // Event record at the default counter width.
  typedef struct packed {
    logic                     wrap;
    logic                     match;
    logic [CNT_W_DEFAULT-1:0] value;
  } evt_rec_t;

  // Builds a default-width event record from its fields.
  function automatic evt_rec_t make_evt(input logic                     wrap,
                                        input logic                     match,
                                        input logic [CNT_W_DEFAULT-1:0] value);
    evt_rec_t rec;
    rec.wrap  = wrap;
    rec.match = match;
    rec.value = value;
    return rec;
  endfunction

endpackage
`default_nettype wire

// File: rtl/event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : event_fifo
// Description : Show-ahead synchronous FIFO. Head entry is always visible on
//               dout_o. A push into a full FIFO is accepted only when a pop
//               happens in the same cycle; otherwise it is ignored.
//               DEPTH must be a power of two and at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module event_fifo
  import count_mon_pkg::*;
#(
  parameter int WIDTH = CNT_W_DEFAULT + 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q,  level_d;
  logic             do_push;
  logic             do_pop;

  // Qualify the requests: pop needs data, push needs room or a concurrent pop.
  always_comb begin
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
  end

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage; cleared on reset so the head reads as zero after reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Status and show-ahead head output, all from registered state.
  always_comb begin
    dout_o  = mem_q[rd_ptr_q];
    level_o = level_q;
    full_o  = (level_q == LVL_W'(DEPTH));
    empty_o = (level_q == '0);
  end

endmodule
`default_nettype wire

// File: rtl/count_event_monitor.sv
`default_nettype none
// ============================================================================
// Module      : count_event_monitor
// Description : Samples a free-running counter every clock, detects wrap
//               (all-ones to zero) and compare-match events, queues them as
//               {wrap, match, value} records and drains them over a
//               valid/ready interface. Keeps a saturating wrap tally and a
//               sticky flag for events lost to a full queue.
// Revision    : 1.0 - initial release
// ============================================================================
module count_event_monitor
  import count_mon_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int DEPTH   = 4,
  parameter int TALLY_W = TALLY_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [CNT_W-1:0]       cnt_i,
  input  logic                   cmp_en_i,
  input  logic [CNT_W-1:0]       cmp_val_i,
  output logic                   evt_valid_o,
  input  logic                   evt_ready_i,
  output logic [CNT_W+1:0]       evt_data_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o,
  output logic [TALLY_W-1:0]     wrap_cnt_o
);

  logic [CNT_W-1:0]   prev_q;
  logic               prev_vld_q;
  logic [TALLY_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic               overflow_q, overflow_d;

  logic               wrap;
  logic               match;
  logic               push;
  logic               pop;
  logic [CNT_W+1:0]   evt_rec;
  logic               fifo_full;
  logic               fifo_empty;

  // Event detection. A held counter value matches only on the cycle it
  // first appears; the first sample after reset can never be a wrap.
  always_comb begin
    wrap    = prev_vld_q & (prev_q == '1) & (cnt_i == '0);
    match   = cmp_en_i & (cnt_i == cmp_val_i) & (~prev_vld_q | (cnt_i != prev_q));
    push    = wrap | match;
    pop     = evt_valid_o & evt_ready_i;
    evt_rec = {wrap, match, cnt_i};
  end

  // Sample register for the previous counter value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      prev_q     <= cnt_i;
      prev_vld_q <= 1'b1;
    end
  end

  // Tally and loss-flag next-state: tally saturates, overflow is sticky and
  // set only when a push meets a full queue with no pop to make room.
  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    overflow_d = overflow_q;
    if (wrap && (wrap_cnt_q != '1)) begin
      wrap_cnt_d = wrap_cnt_q + TALLY_W'(1);
    end
    if (push && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  // Tally and loss-flag registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wrap_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrap_cnt_q <= wrap_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  event_fifo #(
    .WIDTH (CNT_W + 2),
    .DEPTH (DEPTH)
  ) u_event_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .din_i   (evt_rec),
    .pop_i   (pop),
    .dout_o  (evt_data_o),
    .level_o (level_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Output drive; valid comes from registered occupancy only.
  always_comb begin
    evt_valid_o = ~fifo_empty;
    overflow_o  = overflow_q;
    wrap_cnt_o  = wrap_cnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_count_event_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_event_monitor
// Description : Scoreboard bench for count_event_monitor. Expected records
//               are queued as stimulus is driven and compared against the
//               head of the DUT queue whenever a record is handed over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_event_monitor;
  import count_mon_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] cnt_i = '0;
  logic       cmp_en_i = 1'b0;
  logic [3:0] cmp_val_i = '0;
  logic       evt_valid_o;
  logic       evt_ready_i = 1'b0;
  logic [5:0] evt_data_o;
  logic [2:0] level_o;
  logic       overflow_o;
  logic [7:0] wrap_cnt_o;

  count_event_monitor #(
    .CNT_W   (4),
    .DEPTH   (DEPTH),
    .TALLY_W (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cnt_i       (cnt_i),
    .cmp_en_i    (cmp_en_i),
    .cmp_val_i   (cmp_val_i),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (evt_ready_i),
    .evt_data_o  (evt_data_o),
    .level_o     (level_o),
    .overflow_o  (overflow_o),
    .wrap_cnt_o  (wrap_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [5:0] sb[$];
  logic [3:0] m_prev;
  bit         m_prev_vld;
  bit         m_ovf;
  int         m_wrap;
  int         n_pops;
  logic [5:0] last_pop;

  int n_vec;
  int n_mis;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Hold reset low for n cycles with random counter values, then check
  // the cleared state. Reset is released by the next step.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset_n     = 1'b0;
      cnt_i       = 4'($urandom_range(0, 15));
      evt_ready_i = 1'($urandom_range(0, 1));
      cmp_en_i    = 1'b0;
      @(posedge clk);
      #1;
    end
    sb.delete();
    m_prev     = '0;
    m_prev_vld = 1'b0;
    m_ovf      = 1'b0;
    m_wrap     = 0;
    check_eq("rst_valid", evt_valid_o, 0);
    check_eq("rst_data",  evt_data_o,  0);
    check_eq("rst_level", level_o,     0);
    check_eq("rst_ovf",   overflow_o,  0);
    check_eq("rst_wrap",  wrap_cnt_o,  0);
  endtask

  // One clock of stimulus with model update and post-edge checks.
  task automatic step(input logic [3:0] cnt, input bit en, input logic [3:0] cv, input bit rdy);
    bit         w;
    bit         m;
    bit         p;
    logic [5:0] rec;
    @(negedge clk);
    reset_n     = 1'b1;
    cnt_i       = cnt;
    cmp_en_i    = en;
    cmp_val_i   = cv;
    evt_ready_i = rdy;
    check_eq("valid", evt_valid_o, (sb.size() != 0));
    w = m_prev_vld && (m_prev == 4'hF) && (cnt == 4'h0);
    m = en && (cnt == cv) && (!m_prev_vld || (cnt != m_prev));
    p = rdy && (sb.size() != 0);
    if (p) begin
      rec = sb.pop_front();
      check_eq("head", evt_data_o, rec);
      n_pops++;
      last_pop = rec;
    end
    if (w || m) begin
      if (sb.size() == DEPTH) m_ovf = 1'b1;
      else sb.push_back({w, m, cnt});
    end
    if (w && (m_wrap < 255)) m_wrap++;
    m_prev     = cnt;
    m_prev_vld = 1'b1;
    @(posedge clk);
    #1;
    check_eq("level",    level_o,    sb.size());
    check_eq("ovf",      overflow_o, m_ovf);
    check_eq("wrap_cnt", wrap_cnt_o, m_wrap);
  endtask

  // Three-value pattern that hits 5 once per period without any wrap.
  task automatic match_periods(input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      step(4'd4, 1'b1, 4'd5, rdy);
      step(4'd5, 1'b1, 4'd5, rdy);
      step(4'd6, 1'b1, 4'd5, rdy);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    n_vec = 0; n_mis = 0; n_pops = 0; last_pop = '0;
    m_prev = '0; m_prev_vld = 1'b0; m_ovf = 1'b0; m_wrap = 0;

    // 1. Reset, then first sample of 0 must not wrap
    do_reset(2);
    step(4'd0, 1'b0, 4'd0, 1'b1);
    check_eq("t1_no_evt", evt_valid_o, 0);

    // 2. Free-running wrap with compare disabled
    p0 = n_pops;
    for (int k = 1; k <= 20; k++) begin
      step(4'(k % 16), 1'b0, 4'd0, 1'b1);
      if (k == 16) check_eq("t2_latency", evt_valid_o, 1);
    end
    check_eq("t2_pops", n_pops - p0, 1);
    check_eq("t2_rec", last_pop, 6'h20);
    check_eq("t2_wrapflag", last_pop[EVT_WRAP_BIT], 1);
    check_eq("t2_tally", wrap_cnt_o, 1);

    // 3. Combined wrap+match, then stalled match
    p0 = n_pops;
    step(4'd13, 1'b1, 4'd0, 1'b1);
    step(4'd14, 1'b1, 4'd0, 1'b1);
    step(4'd15, 1'b1, 4'd0, 1'b1);
    step(4'd0,  1'b1, 4'd0, 1'b1);
    step(4'd1,  1'b1, 4'd0, 1'b1);
    check_eq("t3_combined", last_pop, 6'h30);
    for (int k = 2; k <= 4; k++) step(4'(k), 1'b1, 4'd5, 1'b1);
    for (int k = 0; k < 3; k++) step(4'd5, 1'b1, 4'd5, 1'b1);
    step(4'd6, 1'b1, 4'd5, 1'b1);
    step(4'd7, 1'b1, 4'd5, 1'b1);
    check_eq("t3_pops", n_pops - p0, 2);
    check_eq("t3_stall", last_pop, 6'h15);

    // 4. Overflow, then drain
    match_periods(5, 1'b0);
    check_eq("t4_level", level_o, 4);
    check_eq("t4_ovf", overflow_o, 1);
    p0 = n_pops;
    for (int k = 0; k < 6; k++) step(4'd6, 1'b0, 4'd5, 1'b1);
    check_eq("t4_drained", n_pops - p0, 4);
    check_eq("t4_last", last_pop, 6'h15);
    check_eq("t4_empty", evt_valid_o, 0);
    check_eq("t4_ovf_sticky", overflow_o, 1);

    // 5. Full FIFO with simultaneous push and pop
    do_reset(1);
    match_periods(4, 1'b0);
    check_eq("t5_full", level_o, 4);
    step(4'd4, 1'b1, 4'd5, 1'b0);
    step(4'd5, 1'b1, 4'd5, 1'b1);
    check_eq("t5_level", level_o, 4);
    check_eq("t5_ovf", overflow_o, 0);
    for (int k = 0; k < 5; k++) step(4'd6, 1'b1, 4'd5, 1'b1);
    check_eq("t5_empty", level_o, 0);

    // 6. Tally saturation, then reset with entries queued
    for (int k = 0; k < 4800; k++) step(4'((7 + k) % 16), 1'b0, 4'd0, 1'b1);
    check_eq("t6_sat", wrap_cnt_o, 255);
    match_periods(3, 1'b0);
    check_eq("t6_level3", level_o, 3);
    @(negedge clk);
    cnt_i = 4'hF;
    do_reset(1);
    step(4'd0, 1'b0, 4'd0, 1'b1);
    check_eq("t6_no_wrap", wrap_cnt_o, 0);
    check_eq("t6_no_evt", evt_valid_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/count_event_monitor.md
# count_event_monitor

Downstream consumer of the 4-bit synchronous counter. Samples the counter value every clock and detects two events: wrap-around (all-ones to zero) and a programmable compare match. Each event is queued as a record in a small FIFO and drained over a valid/ready interface. The block also keeps a saturating wrap tally and a sticky overflow flag for event loss.

## Interface
- `CNT_W`, 4: width of the sampled counter value.
- `DEPTH`, 4: event FIFO depth; must be a power of two and at least 2.
- `TALLY_W`, 8: width of the saturating wrap tally.

Clock and reset are fixed: one clock, `clk`; reset `reset_n` is synchronous and active-low.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `cnt_i`  in  CNT_W  counter value (counter Q output).
- `cmp_en_i`  in  1  enables compare-match detection.
- `cmp_val_i`  in  CNT_W  compare value.
- `evt_valid_o`  out  1  head event is available.
- `evt_ready_i`  in  1  consumer accepts the head event.
- `evt_data_o`  out  CNT_W+2  event record, packed as {wrap, match, value}.
- `level_o`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `overflow_o`  out  1  sticky; set when an event is dropped.
- `wrap_cnt_o`  out  TALLY_W  saturating count of wraps.

## Operation
- **Sample register.** `prev_q` captures `cnt_i` every cycle. `prev_vld` is 0 after reset and becomes 1 after the first sample.
- **Wrap detect.** `wrap` = `prev_vld` & (`prev_q` == all-ones) & (`cnt_i` == 0).
- **Match detect.** `match` = `cmp_en_i` & (`cnt_i` == `cmp_val_i`) & (!`prev_vld` | `cnt_i` != `prev_q`).
  - A stalled counter therefore produces exactly one match.
- **Push.** `push` = `wrap` | `match`. The pushed record is {`wrap`, `match`, `cnt_i`}. A cycle with both events pushes one record with both flags set.
- **Pop.** `pop` = `evt_valid_o` & `evt_ready_i`.
- **FIFO.** Show-ahead: `evt_data_o` always reflects the head entry. `evt_valid_o` = (`level_o` != 0).
- **Full FIFO.**
  - Push with no pop: the record is dropped and `overflow_o` is set to 1.
  - Push together with pop: both are performed, the record is accepted, and `level_o` is unchanged.
- **Empty FIFO with push and no pop.** The record becomes the head on the next cycle. There is no bypass, so `evt_valid_o` is never combinational from `cnt_i`.
- **Overflow clear.** `overflow_o` is cleared only by reset.
- **Wrap tally.** `wrap_cnt_o` increments on every `wrap`, independent of FIFO state, and saturates at 2^TALLY_W−1.
- **Pointers.** Read/write pointers are log2(DEPTH) bits and wrap naturally. Occupancy is a separate up/down counter.

## Timing
- **Reset values.** When `reset_n` is sampled low, the following are all 0 on the next cycle:
  - outputs `evt_valid_o`, `evt_data_o`, `level_o`, `overflow_o`, `wrap_cnt_o`;
  - internal state `prev_vld`, `prev_q` and both pointers.
- **Reset mid-operation.** Any queued events are discarded. The first `cnt_i` sample after reset can never signal a wrap.
- **Latency.** An event detected in cycle N gives `evt_valid_o` = 1 in cycle N+1 when the FIFO was empty.
- **Handshake.**
  - While `evt_valid_o` & !`evt_ready_i`, `evt_data_o` holds stable.
  - `evt_ready_i` may be high with `evt_valid_o` low; no effect.
  - One record transfers per cycle in which `pop` is true.
- **Throughput.** One push and one pop per cycle sustained.

## Structure
- **Shared package `count_mon_pkg`:**
  - CNT_W default;
  - bit-position constants `EVT_WRAP_BIT` = CNT_W+1 and `EVT_MATCH_BIT` = CNT_W;
  - packed event record typedef;
  - TALLY_W default.
- **Sub-module `event_fifo`:** synchronous FIFO with parameters WIDTH and DEPTH. Ports: `clk`, `reset_n`, push, data in, pop, data out, level, full, empty.
- **Top level:** detect logic, wrap tally and overflow flag only.

## Test plan
1. **Reset.** Drive `reset_n` = 0 for 2 cycles with random `cnt_i` → `evt_valid_o`, `level_o`, `overflow_o`, `wrap_cnt_o` all 0; no event on the first sample after release.
2. **Free-running wrap.** Free-running counter 0..15..0, `cmp_en_i` = 0, `evt_ready_i` = 1 → one record 6'h20 one cycle after `cnt_i` = 0 is sampled; `wrap_cnt_o` = 1; no other events.
3. **Combined and stalled match.**
   - `cmp_en_i` = 1, `cmp_val_i` = 0 across a wrap → single record 6'h30.
   - Then `cmp_val_i` = 5 with the counter held at 5 for 3 cycles → exactly one record 6'h15.
4. **Overflow and drain.** `evt_ready_i` = 0, `cmp_val_i` = 5, five counter periods → `level_o` reaches 4, fifth event dropped, `overflow_o` = 1. Then `evt_ready_i` = 1 → four records 6'h15 drained in order, `evt_valid_o` falls to 0, `overflow_o` stays 1.
5. **Full with simultaneous push and pop.** FIFO full, `evt_ready_i` = 1 and a new match in the same cycle → record accepted, `level_o` stays 4, `overflow_o` stays 0.
6. **Tally saturation and mid-operation reset.**
   - 300 wraps → `wrap_cnt_o` = 255.
   - Then pulse `reset_n` low for 1 cycle with `level_o` = 3 → next cycle `level_o` = 0, `wrap_cnt_o` = 0, `overflow_o` = 0.
